// File: rtl/i2c_slave_target.sv
// I2C target: fixed 7-bit address, ACKs writes, serves reads.
// SCL/SDA are oversampled on clk; SDA_o is open-drain style.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       addr_match,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_s, sda_s;
  logic scl_d, sda_d;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;
  logic fall_q;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [6:0] tx_shift;
  logic       ack_due;
  logic       mack;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // Bus input synchronisers plus one edge-detect flop; idle bus is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      fall_q   <= scl_fall;
    end
  end

  // Protocol FSM; SDA only moves one clk after a detected SCL fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      i2c_sda_o  <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      addr_match <= 1'b0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_shift   <= '0;
      ack_due    <= 1'b0;
      mack       <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= '0;
        addr_match <= 1'b0;
        rw         <= 1'b0;
        i2c_sda_o  <= 1'b1;
        busy       <= 1'b1;
        ack_due    <= 1'b0;
      end else if (stop_det) begin
        state      <= IDLE;
        i2c_sda_o  <= 1'b1;
        busy       <= 1'b0;
        addr_match <= 1'b0;
        bit_cnt    <= '0;
        ack_due    <= 1'b0;
      end else begin
        unique case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift == SLAVE_ADDR) ack_due <= 1'b1;
                else state <= WAIT_STOP;
              end
            end else if (fall_q && ack_due) begin
              ack_due    <= 1'b0;
              i2c_sda_o  <= 1'b0;
              addr_match <= 1'b1;
              rw         <= shift[0];
              state      <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (fall_q) begin
              bit_cnt <= '0;
              if (rw) begin
                tx_shift  <= tx_data[6:0];
                tx_load   <= 1'b1;
                i2c_sda_o <= tx_data[7];
                state     <= RD_DATA;
              end else begin
                i2c_sda_o <= 1'b1;
                state     <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {shift, sda_s};
                rx_valid <= 1'b1;
                ack_due  <= 1'b1;
              end
            end else if (fall_q && ack_due) begin
              ack_due   <= 1'b0;
              i2c_sda_o <= 1'b0;
              state     <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (fall_q) begin
              i2c_sda_o <= 1'b1;
              state     <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (fall_q) begin
              if (bit_cnt == 3'd7) begin
                i2c_sda_o <= 1'b1;
                bit_cnt   <= '0;
                state     <= RD_ACK;
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                i2c_sda_o <= tx_shift[6];
                tx_shift  <= {tx_shift[5:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              mack <= sda_s;
            end else if (fall_q) begin
              if (mack) begin
                state <= WAIT_STOP;
              end else begin
                tx_shift  <= tx_data[6:0];
                tx_load   <= 1'b1;
                i2c_sda_o <= tx_data[7];
                bit_cnt   <= '0;
                state     <= RD_DATA;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-banged master, wired-AND SDA,
// random transfers checked against expected bus results.
module tb_i2c_slave_target;

  localparam logic [6:0] ADDR = 7'h55;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = '0;
  logic       sda_o;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, addr_match, rw, busy;
  wire        sda_bus = m_sda & sda_o;

  int n_cmp = 0;
  int n_bad = 0;
  int ntx = 0;
  logic [7:0] rxq[$];
  logic [7:0] wdata[4];
  logic [7:0] rdata[4];

  i2c_slave_target #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .i2c_scl(scl),
    .i2c_sda_i(sda_bus),
    .i2c_sda_o(sda_o),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_load(tx_load),
    .addr_match(addr_match),
    .rw(rw),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every received byte and every tx latch.
  always @(posedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_load) ntx++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      tick(3); m_sda = 1'b1;
      tick(H); scl = 1'b1;
      tick(H);
    end
    m_sda = 1'b0;
    tick(H); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(3); m_sda = 1'b0;
    tick(H); scl = 1'b1;
    tick(H); m_sda = 1'b1;
    tick(H);
  endtask

  task automatic wr_bit(input logic b);
    tick(3); m_sda = b;
    tick(H); scl = 1'b1;
    tick(H); scl = 1'b0;
  endtask

  task automatic rd_bit(output logic b);
    tick(3); m_sda = 1'b1;
    tick(H); scl = 1'b1;
    tick(H/2); b = sda_bus;
    tick(H/2); scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(ack);
  endtask

  task automatic xfer_write(input logic [6:0] a, input int n);
    logic ack;
    logic hit;
    int   rx0;
    hit = (a == ADDR);
    rx0 = rxq.size();
    i2c_start();
    chk("busy_start", busy, 1);
    wr_byte({a, 1'b0}, ack);
    chk("w_addr_ack", ack, !hit);
    chk("w_match", addr_match, hit);
    chk("w_rw", rw, 0);
    for (int k = 0; k < n; k++) begin
      wr_byte(wdata[k], ack);
      chk("w_data_ack", ack, !hit);
    end
    chk("w_busy_mid", busy, 1);
    i2c_stop();
    chk("w_busy_stop", busy, 0);
    chk("w_match_stop", addr_match, 0);
    chk("w_rx_cnt", rxq.size() - rx0, hit ? n : 0);
    if (hit) begin
      for (int k = 0; k < n; k++)
        if (rx0 + k < rxq.size()) chk("w_rx_byte", rxq[rx0+k], wdata[k]);
      chk("w_rx_data", rx_data, wdata[n-1]);
    end
  endtask

  task automatic xfer_read(input logic [6:0] a, input int n);
    logic       ack;
    logic       hit;
    logic [7:0] b;
    int         t0;
    hit = (a == ADDR);
    t0 = ntx;
    tx_data = rdata[0];
    i2c_start();
    wr_byte({a, 1'b1}, ack);
    chk("r_addr_ack", ack, !hit);
    chk("r_match", addr_match, hit);
    chk("r_rw", rw, hit);
    if (hit) begin
      for (int k = 0; k < n; k++) begin
        for (int i = 7; i >= 0; i--) begin
          rd_bit(b[i]);
          if (i == 7) tx_data = (k + 1 < n) ? rdata[k+1] : 8'($urandom);
        end
        chk("r_byte", b, rdata[k]);
        wr_bit(k == n - 1);
      end
      tick(6);
      chk("r_nack_rel", sda_o, 1);
    end
    i2c_stop();
    chk("r_busy_stop", busy, 0);
    chk("r_match_stop", addr_match, 0);
    chk("r_tx_cnt", ntx - t0, hit ? n : 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    logic [6:0] a;
    int         rx0, n;

    tick(3);
    chk("rst_sda", sda_o, 1);
    chk("rst_rx", rx_data, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_txl", tx_load, 0);
    chk("rst_match", addr_match, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(5);

    wdata[0] = 8'hAA;
    xfer_write(7'h55, 1);
    wdata[0] = 8'h12;
    xfer_write(7'h54, 1);
    rdata[0] = 8'h01;
    xfer_read(7'h55, 1);
    rdata[0] = 8'hC3;
    rdata[1] = 8'h5A;
    xfer_read(7'h55, 2);

    // Partial write then repeated START into a read.
    rx0 = rxq.size();
    i2c_start();
    wr_byte({ADDR, 1'b0}, ack);
    chk("p_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) wr_bit(1'($urandom));
    tx_data = 8'h96;
    i2c_start();
    wr_byte({ADDR, 1'b1}, ack);
    chk("rs_addr_ack", ack, 0);
    chk("rs_rw", rw, 1);
    chk("rs_match", addr_match, 1);
    for (int i = 7; i >= 0; i--) rd_bit(b[i]);
    chk("rs_byte", b, 8'h96);
    wr_bit(1'b1);
    i2c_stop();
    chk("rs_no_rxv", rxq.size() - rx0, 0);

    // Partial write then STOP.
    i2c_start();
    wr_byte({ADDR, 1'b0}, ack);
    for (int i = 0; i < 4; i++) wr_bit(1'($urandom));
    i2c_stop();
    chk("ps_no_rxv", rxq.size() - rx0, 0);
    chk("ps_busy", busy, 0);

    // Reset while the target holds the address ACK low.
    i2c_start();
    for (int i = 7; i >= 1; i--) wr_bit(ADDR[i-1]);
    wr_bit(1'b0);
    tick(6);
    chk("ra_ack_low", sda_o, 0);
    reset = 1'b0;
    #1;
    chk("ra_sda_async", sda_o, 1);
    tick(2);
    chk("ra_busy", busy, 0);
    chk("ra_match", addr_match, 0);
    chk("ra_rw", rw, 0);
    chk("ra_rx", rx_data, 0);
    scl = 1'b1;
    tick(3);
    m_sda = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(5);
    wdata[0] = 8'h3C;
    xfer_write(7'h55, 1);

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      a = ADDR;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom);
        if (a == ADDR) a = 7'h2A;
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        wdata[k] = 8'($urandom);
        rdata[k] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) xfer_read(a, n);
      else xfer_write(a, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
